// File: rtl/spike_raster_buffer.sv
// -----------------------------------------------------------------------------
// spike_raster_buffer
//
// Purpose:
//   Runs on the neuron clock. Uses the neuron-clock generator's 8-bit slot
//   counter to sample one spike bit per neuron per sweep (128 neurons, two
//   slots each). Packs the bits into 32-bit raster words, four words per sweep.
//   Each word carries a {frame, word_idx} tag. Words are queued in a FIFO for
//   host readout. Words lost to a full FIFO are flagged and counted.
//
// Ports:
//   i_clk         neuron clock
//   i_reset       synchronous, active-high; clears all state
//   i_neuron_cnt  slot counter; neuron index = cnt[7:1]
//   i_spike_in    spike of neuron cnt[7:1], valid when cnt[0]==1
//   i_enable      level; request capture
//   i_clear_ovf   pulse; clears overflow flag and drop counter
//   i_rd_en       host read strobe
//   o_rd_data     raster word; bit b = neuron (word_idx*32 + b)
//   o_rd_tag      {frame, word_idx}
//   o_rd_valid    one-cycle pulse, read data valid (latency 1 after i_rd_en)
//   o_empty       FIFO empty
//   o_fifo_count  words stored
//   o_capturing   high while capturing or draining the final sweep
//   o_overflow    sticky; a word was dropped
//   o_drop_cnt    dropped words, saturating
// -----------------------------------------------------------------------------
module spike_raster_buffer #(
    parameter int DEPTH   = 16,
    parameter int FRAME_W = 10,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_neuron_cnt,
    input  logic               i_spike_in,
    input  logic               i_enable,
    input  logic               i_clear_ovf,
    input  logic               i_rd_en,
    output logic [31:0]        o_rd_data,
    output logic [FRAME_W+1:0] o_rd_tag,
    output logic               o_rd_valid,
    output logic               o_empty,
    output logic [AW:0]        o_fifo_count,
    output logic               o_capturing,
    output logic               o_overflow,
    output logic [15:0]        o_drop_cnt
);

    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

    state_t               r_state, w_state_nxt;
    logic [FRAME_W-1:0]   r_frame;
    logic [31:0]          r_pack;
    logic [31:0]          r_mem_data [DEPTH];
    logic [FRAME_W+1:0]   r_mem_tag  [DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [AW:0]          r_count;
    logic [31:0]          r_rd_data;
    logic [FRAME_W+1:0]   r_rd_tag;
    logic                 r_rd_valid;
    logic                 r_overflow;
    logic [15:0]          r_drop_cnt;

    logic [6:0]  w_idx;
    logic [4:0]  w_bit;
    logic [1:0]  w_word;
    logic        w_odd, w_sweep_start, w_sweep_end;
    logic        w_active, w_word_done, w_rd, w_wr_ok, w_drop;
    logic [31:0] w_wr_data;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_idx         = i_neuron_cnt[7:1];
    assign w_bit         = w_idx[4:0];
    assign w_word        = w_idx[6:5];
    assign w_odd         = i_neuron_cnt[0];
    assign w_sweep_start = (i_neuron_cnt == 8'd0);
    // Slot 255 is the second slot of neuron 127: the last edge of a sweep.
    assign w_sweep_end   = (i_neuron_cnt == 8'hFF);

    assign w_active    = (r_state == S_CAPTURE) || (r_state == S_DRAIN);
    assign w_word_done = w_active && w_odd && (w_bit == 5'd31);
    // The final bit bypasses the pack register so the word is written this cycle.
    assign w_wr_data   = {i_spike_in, r_pack[30:0]};

    assign w_rd    = i_rd_en && (r_count != '0);
    // A pop on the same edge frees the slot the push lands in.
    assign w_wr_ok = w_word_done && ((r_count < C_FULL) || w_rd);
    assign w_drop  = w_word_done && !w_wr_ok;

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_enable) w_state_nxt = S_ARMED;
            S_ARMED: begin
                if (!i_enable)          w_state_nxt = S_IDLE;
                else if (w_sweep_start) w_state_nxt = S_CAPTURE;
            end
            // Dropping enable on the very last slot ends the sweep directly;
            // otherwise the current sweep is finished in DRAIN.
            S_CAPTURE: if (!i_enable) w_state_nxt = w_sweep_end ? S_IDLE : S_DRAIN;
            S_DRAIN:   if (w_sweep_end) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_frame <= '0;
            r_pack  <= '0;
        end else begin
            r_state <= w_state_nxt;
            // The first sweep after arming keeps the current frame number.
            if ((r_state == S_CAPTURE) && w_sweep_start)
                r_frame <= r_frame + 1'b1;
            if (w_active && w_odd) begin
                if (w_bit == 5'd31) r_pack <= '0;
                else                r_pack[w_bit] <= i_spike_in;
            end
        end
    end

    // FIFO storage holds no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok && !i_reset) begin
            r_mem_data[r_wptr] <= w_wr_data;
            r_mem_tag[r_wptr]  <= {r_frame, w_word};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_tag   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_data <= r_mem_data[r_rptr];
                r_rd_tag  <= r_mem_tag[r_rptr];
                r_rptr    <= r_rptr + 1'b1;
            end
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            case ({w_wr_ok, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop on the same edge as clear_ovf wins and restarts the count at 1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= i_clear_ovf ? 16'd1 : sat_inc16(r_drop_cnt);
        end else if (i_clear_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_rd_tag     = r_rd_tag;
    assign o_rd_valid   = r_rd_valid;
    assign o_empty      = (r_count == '0);
    assign o_fifo_count = r_count;
    assign o_capturing  = w_active;
    assign o_overflow   = r_overflow;
    assign o_drop_cnt   = r_drop_cnt;

endmodule
